// File: rtl/bcd_pkg.sv
// Shared constants for the BCD display path: segment patterns (active-high,
// bit order {g,f,e,d,c,b,a}) and the scan slot encoding.
package bcd_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        SLOT_ONES     = 2'd0,
        SLOT_TENS     = 2'd1,
        SLOT_HUNDREDS = 2'd2,
        SLOT_SIGN     = 2'd3
    } slot_t;

    function automatic slot_t nextSlot(input slot_t s);
        case (s)
            SLOT_ONES:     return SLOT_TENS;
            SLOT_TENS:     return SLOT_HUNDREDS;
            SLOT_HUNDREDS: return SLOT_SIGN;
            default:       return SLOT_ONES;
        endcase
    endfunction

endpackage

// File: rtl/bcd_seg_mux_if.sv
// Bundle between the BCD converter result / display pins and the display stage.
interface bcd_seg_mux_if;

    logic       sign;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       data_ready;
    logic [6:0] seg;
    logic [3:0] an;
    logic       disp_valid;
    logic       err;

    modport master (
        output sign, hundreds, tens, ones, data_ready,
        input  seg, an, disp_valid, err
    );

    modport slave (
        input  sign, hundreds, tens, ones, data_ready,
        output seg, an, disp_valid, err
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational 7-segment decoder: blank wins over dash, dash wins over the
// nibble; nibbles above 9 render as 'E'. Output is active-high.
module seg7_decode
    import bcd_pkg::*;
(
    input  logic       i_blank,
    input  logic       i_dash,
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else if (i_dash) begin
            o_seg = SEG_DASH;
        end else begin
            case (i_nibble)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_E;
            endcase
        end
    end

endmodule

// File: rtl/bcd_seg_mux.sv
// 4-digit multiplexed 7-segment display stage: captures sign/hundreds/tens/ones
// on data_ready and scans them out with leading-zero blanking and 'E' for bad digits.
module bcd_seg_mux
    import bcd_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int LZ_BLANK       = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic          clk,
    input  logic          rst,
    bcd_seg_mux_if.slave  bus
);

    localparam int              CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0]      SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [3:0]      AN_OFF  = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    logic             r_sign;
    logic [3:0]       r_hundreds;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic             r_valid;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    slot_t            r_slot;
    logic [6:0]       r_seg;
    logic [3:0]       r_an;

    logic             w_anyBad;
    logic             w_blank;
    logic             w_dash;
    logic [3:0]       w_nibble;
    logic [6:0]       w_segPat;
    logic [3:0]       w_anHot;

    assign w_anyBad = (bus.hundreds > 4'd9) || (bus.tens > 4'd9) || (bus.ones > 4'd9);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sign     <= 1'b0;
            r_hundreds <= 4'd0;
            r_tens     <= 4'd0;
            r_ones     <= 4'd0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else if (bus.data_ready) begin
            r_sign     <= bus.sign;
            r_hundreds <= bus.hundreds;
            r_tens     <= bus.tens;
            r_ones     <= bus.ones;
            r_valid    <= 1'b1;
            r_err      <= w_anyBad;
        end
    end

    // The scan is parked at slot0 until the first capture, so a fresh display
    // always starts its first frame on the ones digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_slot <= SLOT_ONES;
        end else if (!r_valid) begin
            r_cnt  <= '0;
            r_slot <= SLOT_ONES;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt  <= '0;
            r_slot <= nextSlot(r_slot);
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    // A digit above 9 is never zero, so it naturally defeats leading-zero blanking.
    always_comb begin
        w_blank  = 1'b0;
        w_dash   = 1'b0;
        w_nibble = 4'd0;
        case (r_slot)
            SLOT_ONES: begin
                w_nibble = r_ones;
            end
            SLOT_TENS: begin
                w_nibble = r_tens;
                w_blank  = (LZ_BLANK != 0) && (r_hundreds == 4'd0) && (r_tens == 4'd0);
            end
            SLOT_HUNDREDS: begin
                w_nibble = r_hundreds;
                w_blank  = (LZ_BLANK != 0) && (r_hundreds == 4'd0);
            end
            default: begin
                w_dash  = r_sign;
                w_blank = !r_sign;
            end
        endcase
    end

    seg7_decode u_decode (
        .i_blank  (w_blank),
        .i_dash   (w_dash),
        .i_nibble (w_nibble),
        .o_seg    (w_segPat)
    );

    assign w_anHot = 4'b0001 << r_slot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
        end else if (!r_valid) begin
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= (SEG_ACTIVE_LOW != 0) ? ~w_segPat : w_segPat;
            r_an  <= (AN_ACTIVE_LOW != 0) ? ~w_anHot : w_anHot;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.disp_valid = r_valid;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_bcd_seg_mux.sv
// Self-checking bench for bcd_seg_mux: two instances (LZ_BLANK = 1 and 0) fed the
// same stimulus, compared every cycle against a timeline-based display model.
module tb_bcd_seg_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tbSign = 1'b0;
    logic [3:0] tbH = 4'd0;
    logic [3:0] tbT = 4'd0;
    logic [3:0] tbO = 4'd0;
    logic       tbDr = 1'b0;
    logic       checkEn = 1'b0;

    int checks = 0;
    int errors = 0;

    bcd_seg_mux_if bus0 ();
    bcd_seg_mux_if bus1 ();

    assign bus0.sign = tbSign;
    assign bus0.hundreds = tbH;
    assign bus0.tens = tbT;
    assign bus0.ones = tbO;
    assign bus0.data_ready = tbDr;
    assign bus1.sign = tbSign;
    assign bus1.hundreds = tbH;
    assign bus1.tens = tbT;
    assign bus1.ones = tbO;
    assign bus1.data_ready = tbDr;

    bcd_seg_mux #(.SCAN_DIV(4), .LZ_BLANK(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dutLz (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    bcd_seg_mux #(.SCAN_DIV(4), .LZ_BLANK(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dutNoLz (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    always #5 clk = ~clk;

    // Display model: the slot on the pins follows from how many edges have elapsed
    // since the first capture; the glyph follows from the last captured value.
    logic [6:0] segTbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};

    function automatic logic [6:0] modelGlyph(input int slot, input logic s, input logic [3:0] h,
                                              input logic [3:0] t, input logic [3:0] o, input bit lz);
        logic [6:0] pat;
        if (slot == 3)      pat = s ? 7'h40 : 7'h00;
        else if (slot == 2) pat = (lz && h == 0) ? 7'h00 : segTbl[h];
        else if (slot == 1) pat = (lz && h == 0 && t == 0) ? 7'h00 : segTbl[t];
        else                pat = segTbl[o];
        return ~pat;
    endfunction

    logic       mValid = 1'b0;
    int         mTicks = 0;
    logic       mSign = 1'b0;
    logic [3:0] mH = 4'd0;
    logic [3:0] mT = 4'd0;
    logic [3:0] mO = 4'd0;
    logic [6:0] expSegLz = 7'h7F;
    logic [6:0] expSegNoLz = 7'h7F;
    logic [3:0] expAn = 4'hF;
    logic       expValid = 1'b0;
    logic       expErr = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mValid     <= 1'b0;
            mTicks     <= 0;
            mSign      <= 1'b0;
            mH         <= 4'd0;
            mT         <= 4'd0;
            mO         <= 4'd0;
            expSegLz   <= 7'h7F;
            expSegNoLz <= 7'h7F;
            expAn      <= 4'hF;
            expValid   <= 1'b0;
            expErr     <= 1'b0;
        end else begin
            if (mValid) begin
                expSegLz   <= modelGlyph((mTicks / 4) % 4, mSign, mH, mT, mO, 1'b1);
                expSegNoLz <= modelGlyph((mTicks / 4) % 4, mSign, mH, mT, mO, 1'b0);
                expAn      <= ~(4'b0001 << ((mTicks / 4) % 4));
                mTicks     <= mTicks + 1;
            end else begin
                expSegLz   <= 7'h7F;
                expSegNoLz <= 7'h7F;
                expAn      <= 4'hF;
            end
            if (tbDr) begin
                mSign    <= tbSign;
                mH       <= tbH;
                mT       <= tbT;
                mO       <= tbO;
                mValid   <= 1'b1;
                expValid <= 1'b1;
                expErr   <= (tbH > 9) || (tbT > 9) || (tbO > 9);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    int         cyc = 0;
    int         lastSlot0 = -1;
    logic [3:0] prevAn = 4'hF;

    always @(negedge clk) begin
        cyc++;
        if (checkEn) begin
            checkOutput("seg_lz", {25'd0, bus0.seg}, {25'd0, expSegLz});
            checkOutput("seg_nolz", {25'd0, bus1.seg}, {25'd0, expSegNoLz});
            checkOutput("an_lz", {28'd0, bus0.an}, {28'd0, expAn});
            checkOutput("an_nolz", {28'd0, bus1.an}, {28'd0, expAn});
            checkOutput("disp_valid", {30'd0, bus0.disp_valid, bus1.disp_valid}, {30'd0, expValid, expValid});
            checkOutput("err", {30'd0, bus0.err, bus1.err}, {30'd0, expErr, expErr});
            if (!rst) begin
                lastSlot0 = -1;
            end else if (bus0.an == 4'hE && prevAn != 4'hE) begin
                if (lastSlot0 >= 0) checkOutput("an_period", cyc - lastSlot0, 16);
                lastSlot0 = cyc;
            end
        end
        prevAn = bus0.an;
    end

    task automatic applyStimulus(input logic s, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        @(posedge clk);
        #1;
        tbSign = s;
        tbH    = h;
        tbT    = t;
        tbO    = o;
        tbDr   = 1'b1;
        @(posedge clk);
        #1;
        tbDr   = 1'b0;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Called right after a first capture following reset: one dark cycle, then
    // a full frame of four slots, four cycles each.
    task automatic checkFrame(input string tag, input logic [3:0][6:0] lzLit, input logic [3:0][6:0] noLzLit);
        logic [3:0][3:0] anLit;
        anLit = {4'h7, 4'hB, 4'hD, 4'hE};
        @(negedge clk);
        checkOutput({tag, "_dark_an"}, {28'd0, bus0.an}, 32'hF);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkOutput($sformatf("%s_seg_lz_c%0d", tag, i), {25'd0, bus0.seg}, {25'd0, lzLit[i / 4]});
            checkOutput($sformatf("%s_seg_nolz_c%0d", tag, i), {25'd0, bus1.seg}, {25'd0, noLzLit[i / 4]});
            checkOutput($sformatf("%s_an_c%0d", tag, i), {28'd0, bus0.an}, {28'd0, anLit[i / 4]});
        end
    endtask

    function automatic logic [3:0] randDigit();
        int pick;
        pick = $urandom_range(0, 9);
        if (pick == 0) return 4'd0;
        if (pick == 1) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        checkEn = 1'b1;

        // Dark after reset, including an async reset pulse mid-run.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("idle_an", {28'd0, bus0.an}, 32'hF);
            checkOutput("idle_seg", {25'd0, bus0.seg}, 32'h7F);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("idle_rst_valid", {31'd0, bus0.disp_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("idle_after_rst_an", {28'd0, bus0.an}, 32'hF);
        checkOutput("idle_after_rst_err", {31'd0, bus0.err}, 32'd0);

        applyStimulus(1'b1, 4'd0, 4'd9, 4'd4);
        checkFrame("neg94", {7'h3F, 7'h7F, 7'h10, 7'h19}, {7'h3F, 7'h40, 7'h10, 7'h19});

        doReset();
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd7);
        checkFrame("pos7", {7'h7F, 7'h7F, 7'h7F, 7'h78}, {7'h7F, 7'h40, 7'h40, 7'h78});

        doReset();
        applyStimulus(1'b0, 4'hA, 4'd1, 4'd2);
        checkOutput("bad_err_set", {31'd0, bus0.err}, 32'd1);
        checkFrame("badA12", {7'h7F, 7'h06, 7'h79, 7'h24}, {7'h7F, 7'h06, 7'h79, 7'h24});
        applyStimulus(1'b0, 4'd1, 4'd2, 4'd3);
        checkOutput("bad_err_clear", {31'd0, bus0.err}, 32'd0);

        // data_ready held high with inputs changing every cycle
        @(posedge clk);
        #1 tbDr = 1'b1;
        for (int i = 0; i < 48; i++) begin
            tbSign = 1'($urandom_range(0, 1));
            tbH    = randDigit();
            tbT    = randDigit();
            tbO    = randDigit();
            @(posedge clk);
            #1;
        end
        tbDr = 1'b0;

        // Async reset mid-slot, then the first capture restarts at slot0
        repeat (6) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkOutput("midslot_rst_an", {28'd0, bus0.an}, 32'hF);
        checkOutput("midslot_rst_seg", {25'd0, bus0.seg}, 32'h7F);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        applyStimulus(1'b1, 4'd0, 4'd9, 4'd4);
        checkFrame("restart", {7'h3F, 7'h7F, 7'h10, 7'h19}, {7'h3F, 7'h40, 7'h10, 7'h19});

        // Random captures, blanking patterns, bad digits and occasional resets
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            rst    = rst ? 1'($urandom_range(0, 99) != 0) : 1'($urandom_range(0, 3) == 0);
            tbSign = 1'($urandom_range(0, 1));
            tbH    = randDigit();
            tbT    = randDigit();
            tbO    = randDigit();
            tbDr   = 1'($urandom_range(0, 6) == 0);
        end
        @(posedge clk);
        #1;
        tbDr = 1'b0;
        rst  = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
